dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Handshaked responder for the CPU data-memory interface.
- Accepts one load/store request at a time from a CPU-side initiator and performs a word access with byte enables against internal storage.
- Returns read data or a write acknowledge after a programmable number of wait cycles.
- Sits between the CPU load/store path and data storage, replacing the zero-wait single-cycle data memory when multi-cycle memory timing must be modelled.

Parameters:
- DEPTH, 64, number of 32-bit words of storage (power of two, 2..4096)
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned
- LATENCY, 2, wait cycles between request accept and response (0..15)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- req_valid  input  1  initiator presents a request
- req_ready  output  1  responder can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, little-endian byte lanes
- req_be  input  4  store byte enables; bit i covers req_wdata[8i+7:8i]; ignored for loads
- rsp_valid  output  1  response available
- rsp_ready  input  1  initiator accepts the response
- rsp_rdata  output  32  load data; 0 for stores and errors
- rsp_err  output  1  access was misaligned or out of range

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; wait counter=0.
  - Storage contents are not reset; completed writes survive reset.
- States:
  - IDLE:
    - req_ready=1.
    - Accept edge T0 is the edge where req_valid=1 in IDLE. At T0 the access executes, rdata/err are registered, then:
      - LATENCY=0: go to RESP.
      - LATENCY>0: go to WAIT with cnt=LATENCY-1.
  - WAIT:
    - req_ready=0.
    - If cnt==0, go to RESP; otherwise cnt decrements.
  - RESP:
    - req_ready=0, rsp_valid=1.
    - rsp_rdata and rsp_err are held stable until rsp_ready=1.
    - On that edge go to IDLE.
- Latency:
  - rsp_valid is first high in the cycle after edge T0+LATENCY.
  - Back-to-back throughput is one request per LATENCY+2 cycles when rsp_ready is held high.
- No combinational path from req_* or rsp_ready to any output. req_ready is decoded from state only.
- Address decode:
  - off = req_addr - BASE_ADDR (32-bit wraparound).
  - idx = off[log2(DEPTH)+1:2].
  - err = (req_addr[1:0]!=0) OR (off >= DEPTH*4).
- Access at T0:
  - Store, no err: each byte lane with req_be[i]=1 is written to storage[idx]; other lanes are unchanged. rdata reg=0.
  - Store with be=4'b0000: no write, err=0, acknowledge still returned.
  - Load, no err: rdata reg = storage[idx] (pre-edge value).
  - err=1: no write, rdata reg=0, err reg=1.
- Request inputs are ignored outside IDLE. The initiator must hold req_* only until accepted.
- Reset mid-operation:
  - Any pending response is dropped and the block returns to IDLE.
  - A store accepted at T0 before reset remains committed.

Decomposition:
- Shared package dmem_responder_pkg:
  - state encoding IDLE=2'd0, WAIT=2'd1, RESP=2'd2
  - WORD_W=32, BE_W=4, CNT_W=4
- Sub-module dmem_resp_array: DEPTH x 32 storage with byte-enabled synchronous write and asynchronous read, no reset.
- The controller FSM, counter, decode and response registers stay in dmem_responder.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Store then load, LATENCY=2, BASE=0:
  - store 32'hDEADBEEF to 0x10 with be=4'hF -> rsp_valid in cycle after T0+2, rdata=0, err=0.
  - load 0x10 -> rdata=32'hDEADBEEF.
- Byte enables:
  - store 32'h11223344 with be=4'b0101 over 32'hDEADBEEF at 0x10.
  - load 0x10 -> 32'hDE22BE44.
- Errors, DEPTH=64:
  - load 0x12 -> err=1, rdata=0.
  - store to 0x100 -> err=1.
  - load of 0x100 after re-mapping BASE_ADDR=0x100 -> err=0.
- Backpressure, LATENCY=0:
  - hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, and a new req_valid is ignored.
  - set rsp_ready=1 -> IDLE next cycle.
- Reset mid-operation:
  - assert reset during WAIT after a store of 32'hCAFEF00D to 0x20 -> rsp_valid=0 immediately.
  - after release, load 0x20 -> 32'hCAFEF00D.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the handshaked data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dmem_responder_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_resp_array.sv
// Word-wide storage with per-byte write enables; contents are never reset.
// Latency: write commits on the rising edge, read is combinational.
// Backpressure: none, a write is taken whenever wrEn is high.
//   clk    - write clock
//   wrEn   - commit wrData lanes selected by wrBe into word wrIdx
//   rdIdx  - read word index, rdData returns the current (pre-edge) contents
module dmem_resp_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wrEn,
  input  logic [AW-1:0]     wrIdx,
  input  logic [BE_W-1:0]   wrBe,
  input  logic [WORD_W-1:0] wrData,
  input  logic [AW-1:0]     rdIdx,
  output logic [WORD_W-1:0] rdData
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wrBe[i]) mem[wrIdx][8*i +: 8] <= wrData[8*i +: 8];
      end
    end
  end

  assign rdData = mem[rdIdx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with a programmable wait before the response.
// Latency: rsp_valid rises in the cycle after accept edge + LATENCY; one request per LATENCY+2 cycles.
// Backpressure: req_ready only in IDLE; the response is held stable until rsp_ready.
//   clk, reset(active-low, async)
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_be - request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                - response channel
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);
  // WAIT is entered with LATENCY-1 so that RESP follows exactly LATENCY edges after accept.
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       off;
  logic [AW-1:0]     idx;
  logic              accErr;
  logic              accept;
  logic              wrEn;
  logic [WORD_W-1:0] rdData;

  // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
  assign off    = req_addr - BASE_ADDR;
  assign idx    = off[AW+1:2];
  assign accErr = (req_addr[1:0] != 2'b00) || (off >= SPAN);
  assign accept = (state == IDLE) && req_valid;
  assign wrEn   = accept && req_we && !accErr;

  dmem_resp_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk    (clk),
    .wrEn   (wrEn),
    .wrIdx  (idx),
    .wrBe   (req_be),
    .wrData (req_wdata),
    .rdIdx  (idx),
    .rdData (rdData)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rsp_rdata <= (!req_we && !accErr) ? rdData : '0;
            rsp_err   <= accErr;
            cnt       <= CNT_INIT;
            state     <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags come straight from the state register, never from inputs.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int LAT0 = 2;
  localparam int LAT1 = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN      [2];
  logic        reqValid  [2];
  logic        reqReady  [2];
  logic        reqWe     [2];
  logic [31:0] reqAddr   [2];
  logic [31:0] reqWdata  [2];
  logic [3:0]  reqBe     [2];
  logic        rspValid  [2];
  logic        rspReady  [2];
  logic [31:0] rspRdata  [2];
  logic        rspErr    [2];

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  int   latOf [2] = '{LAT0, LAT1};

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .BASE_ADDR(32'h0000_0000), .LATENCY(LAT0)) dut0 (
    .clk(clk), .reset(rstN[0]),
    .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_we(reqWe[0]),
    .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]), .req_be(reqBe[0]),
    .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]),
    .rsp_rdata(rspRdata[0]), .rsp_err(rspErr[0])
  );

  dmem_responder #(.DEPTH(64), .BASE_ADDR(32'h0000_0100), .LATENCY(LAT1)) dut1 (
    .clk(clk), .reset(rstN[1]),
    .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_we(reqWe[1]),
    .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]), .req_be(reqBe[1]),
    .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]),
    .rsp_rdata(rspRdata[1]), .rsp_err(rspErr[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chkIdle(input int d, input string name);
    chk({name, "_reqReady"}, 32'(reqReady[d]), 32'd1);
    chk({name, "_rspValid"}, 32'(rspValid[d]), 32'd0);
  endtask

  // One full transaction: push expectation, drive, wait for accept and response,
  // check latency and payload, complete the handshake, check return to IDLE.
  task automatic doReq(input int d, input vec_t v, input string name);
    int w;
    int lat;
    exp_t e;
    @(negedge clk);
    reqWe[d]    = v.we;
    reqAddr[d]  = v.addr;
    reqWdata[d] = v.wdata;
    reqBe[d]    = v.be;
    reqValid[d] = 1'b1;
    rspReady[d] = 1'b0;
    sb.push_back('{v.expRdata, v.expErr});
    w = 0;
    while (!reqReady[d] && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!reqReady[d]) begin
      chk({name, "_accept_timeout"}, 32'(reqReady[d]), 32'd1);
      reqValid[d] = 1'b0;
      void'(sb.pop_front());
      return;
    end
    @(posedge clk);
    @(negedge clk);
    reqValid[d] = 1'b0;
    lat = 0;
    while (!rspValid[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    if (!rspValid[d]) begin
      chk({name, "_rsp_timeout"}, 32'(rspValid[d]), 32'd1);
      return;
    end
    chk({name, "_latency"}, 32'(lat), 32'(latOf[d]));
    chk({name, "_rdata"}, rspRdata[d], e.rdata);
    chk({name, "_err"}, 32'(rspErr[d]), 32'(e.err));
    rspReady[d] = 1'b1;
    @(negedge clk);
    rspReady[d] = 1'b0;
    chkIdle(d, {name, "_done"});
  endtask

  vec_t tbl0 [12];
  vec_t tbl1 [4];

  initial begin
    for (int d = 0; d < 2; d++) begin
      rstN[d] = 1'b0; reqValid[d] = 1'b0; reqWe[d] = 1'b0; reqAddr[d] = '0;
      reqWdata[d] = '0; reqBe[d] = '0; rspReady[d] = 1'b0;
    end

    //            we    addr          wdata         be       expRdata      expErr
    tbl0[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF,    32'h0,        1'b0};
    tbl0[1]  = '{1'b0, 32'h0000_0010, 32'h0,        4'h0,    32'hDEADBEEF, 1'b0};
    tbl0[2]  = '{1'b1, 32'h0000_0010, 32'h11223344, 4'b0101, 32'h0,        1'b0};
    tbl0[3]  = '{1'b0, 32'h0000_0010, 32'h0,        4'h0,    32'hDE22BE44, 1'b0};
    tbl0[4]  = '{1'b0, 32'h0000_0012, 32'h0,        4'h0,    32'h0,        1'b1};
    tbl0[5]  = '{1'b1, 32'h0000_0100, 32'h0BADF00D, 4'hF,    32'h0,        1'b1};
    tbl0[6]  = '{1'b0, 32'h0000_0100, 32'h0,        4'h0,    32'h0,        1'b1};
    tbl0[7]  = '{1'b1, 32'h0000_0010, 32'hFFFFFFFF, 4'h0,    32'h0,        1'b0};
    tbl0[8]  = '{1'b0, 32'h0000_0010, 32'h0,        4'h0,    32'hDE22BE44, 1'b0};
    tbl0[9]  = '{1'b1, 32'h0000_00FC, 32'hA5C3_5A3C, 4'hF,   32'h0,        1'b0};
    tbl0[10] = '{1'b0, 32'h0000_00FC, 32'h0,        4'h0,    32'hA5C35A3C, 1'b0};
    tbl0[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0,        4'h0,    32'h0,        1'b1};

    tbl1[0]  = '{1'b1, 32'h0000_0100, 32'h12345678, 4'hF,    32'h0,        1'b0};
    tbl1[1]  = '{1'b0, 32'h0000_0100, 32'h0,        4'h0,    32'h12345678, 1'b0};
    tbl1[2]  = '{1'b0, 32'h0000_00FC, 32'h0,        4'h0,    32'h0,        1'b1};
    tbl1[3]  = '{1'b1, 32'h0000_0200, 32'h12345678, 4'hF,    32'h0,        1'b1};

    // Reset held for 3 cycles, then released.
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) chkIdle(d, "in_reset");
    rstN[0] = 1'b1;
    rstN[1] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chkIdle(d, "post_reset");
      chk("post_reset_rdata", rspRdata[d], 32'h0);
      chk("post_reset_err", 32'(rspErr[d]), 32'd0);
    end

    for (int i = 0; i < 12; i++) doReq(0, tbl0[i], $sformatf("l2_vec%0d", i));
    for (int i = 0; i < 4; i++)  doReq(1, tbl1[i], $sformatf("l0_vec%0d", i));

    // Backpressure with LATENCY=0: response held, new request ignored.
    doReq(1, '{1'b1, 32'h104, 32'h55AA55AA, 4'hF, 32'h0, 1'b0}, "bp_store");
    @(negedge clk);
    reqWe[1] = 1'b0; reqAddr[1] = 32'h104; reqValid[1] = 1'b1; rspReady[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reqWe[1] = 1'b1; reqWdata[1] = 32'hFFFF_FFFF; reqBe[1] = 4'hF;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid%0d", k), 32'(rspValid[1]), 32'd1);
      chk($sformatf("bp_rdata%0d", k), rspRdata[1], 32'h55AA55AA);
      chk($sformatf("bp_ready%0d", k), 32'(reqReady[1]), 32'd0);
      @(negedge clk);
    end
    reqValid[1] = 1'b0;
    rspReady[1] = 1'b1;
    @(negedge clk);
    rspReady[1] = 1'b0;
    chkIdle(1, "bp_release");
    doReq(1, '{1'b0, 32'h104, 32'h0, 4'h0, 32'h55AA55AA, 1'b0}, "bp_reload");

    // Reset during WAIT after a store: response dropped, store kept.
    @(negedge clk);
    reqWe[0] = 1'b1; reqAddr[0] = 32'h20; reqWdata[0] = 32'hCAFEF00D; reqBe[0] = 4'hF;
    reqValid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid[0] = 1'b0;
    chk("mid_wait_ready", 32'(reqReady[0]), 32'd0);
    rstN[0] = 1'b0;
    #1;
    chkIdle(0, "mid_rst");
    repeat (2) @(negedge clk);
    rstN[0] = 1'b1;
    @(negedge clk);
    doReq(0, '{1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0}, "rst_reload");

    // Reset while a load response is pending: payload cleared asynchronously.
    @(negedge clk);
    reqWe[0] = 1'b0; reqAddr[0] = 32'h20; reqValid[0] = 1'b1; rspReady[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reqValid[0] = 1'b0;
    repeat (LAT0) @(negedge clk);
    chk("resp_pend_valid", 32'(rspValid[0]), 32'd1);
    chk("resp_pend_rdata", rspRdata[0], 32'hCAFEF00D);
    rstN[0] = 1'b0;
    #1;
    chkIdle(0, "resp_rst");
    chk("resp_rst_rdata", rspRdata[0], 32'h0);
    @(negedge clk);
    rstN[0] = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
